// File: rtl/periph_poll_ctrl_if.sv
// Data-bus port of the poll-then-write sequencer: one request/grant transaction
// channel with address, write data and read data.
interface periph_poll_ctrl_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_gnt_i,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_gnt_i,
      output mem_rdata_i
   );
endinterface

// File: rtl/periph_poll_ctrl.sv
// Hardware poll-then-write sequencer: reads a status register until the masked
// busy bits clear, then writes one word to the data register.
module periph_poll_ctrl #(
   parameter int unsigned MAX_POLLS = 1024,
   parameter int unsigned POLL_GAP  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [31:0]               stat_addr_i,
   input  logic [31:0]               stat_mask_i,
   input  logic [31:0]               data_addr_i,
   input  logic [31:0]               wdata_i,
   periph_poll_ctrl_if.master        mem,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [15:0]               polls_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned PW = 16;
   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_STAT = 2'd1,
      S_GAP     = 2'd2,
      S_WR_DATA = 2'd3
   } state_e;

   state_e          state_q,     state_d;
   logic [DW-1:0]   stat_addr_q, stat_addr_d;
   logic [DW-1:0]   mask_q,      mask_d;
   logic [DW-1:0]   data_addr_q, data_addr_d;
   logic [DW-1:0]   wdata_q,     wdata_d;
   logic [PW-1:0]   polls_q,     polls_d;
   logic [GW-1:0]   gap_q,       gap_d;

   logic            req_q,       req_d;
   logic            we_q,        we_d;
   logic [DW-1:0]   addr_q,      addr_d;
   logic [DW-1:0]   bwdata_q,    bwdata_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;
   logic            err_q,       err_d;

   logic            fin_ok;
   logic            fin_err;
   logic [PW-1:0]   polls_inc;
   logic            stat_clear;
   logic            poll_limit_hit;

   assign polls_inc      = (polls_q == {PW{1'b1}}) ? polls_q : polls_q + PW'(1);
   assign stat_clear     = ((mem.mem_rdata_i & mask_q) == '0);
   assign poll_limit_hit = (MAX_POLLS != 0) && (DW'(polls_inc) == MAX_POLLS);

   // State, operand and registered-output flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         stat_addr_q <= '0;
         mask_q      <= '0;
         data_addr_q <= '0;
         wdata_q     <= '0;
         polls_q     <= '0;
         gap_q       <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         bwdata_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stat_addr_q <= stat_addr_d;
         mask_q      <= mask_d;
         data_addr_q <= data_addr_d;
         wdata_q     <= wdata_d;
         polls_q     <= polls_d;
         gap_q       <= gap_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         bwdata_q    <= bwdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next state, operand latching, poll and gap counters.
   always_comb begin
      state_d     = state_q;
      stat_addr_d = stat_addr_q;
      mask_d      = mask_q;
      data_addr_d = data_addr_q;
      wdata_d     = wdata_q;
      polls_d     = polls_q;
      gap_d       = gap_q;
      fin_ok      = 1'b0;
      fin_err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               stat_addr_d = stat_addr_i;
               mask_d      = stat_mask_i;
               data_addr_d = data_addr_i;
               wdata_d     = wdata_i;
               polls_d     = '0;
               gap_d       = '0;
               state_d     = S_RD_STAT;
            end
         end
         S_RD_STAT: begin
            if (mem.mem_gnt_i) begin
               // A granted read is always counted, even if an abort discards it.
               polls_d = polls_inc;
               if (abort_i) begin
                  fin_err = 1'b1;
               end else if (stat_clear) begin
                  state_d = S_WR_DATA;
               end else if (poll_limit_hit) begin
                  fin_err = 1'b1;
               end else if (POLL_GAP == 0) begin
                  state_d = S_RD_STAT;
               end else begin
                  gap_d   = GW'(POLL_GAP);
                  state_d = S_GAP;
               end
            end else if (abort_i) begin
               fin_err = 1'b1;
            end
         end
         S_GAP: begin
            if (abort_i) begin
               fin_err = 1'b1;
            end else if (gap_q <= GW'(1)) begin
               gap_d   = '0;
               state_d = S_RD_STAT;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         S_WR_DATA: begin
            // A write grant wins over a coincident abort: the write has landed.
            if (mem.mem_gnt_i) begin
               fin_ok = 1'b1;
            end else if (abort_i) begin
               fin_err = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fin_ok || fin_err) begin
         state_d = S_IDLE;
         gap_d   = '0;
      end
   end

   // Output decode from the next state so bus signals are registered.
   always_comb begin
      req_d    = 1'b0;
      we_d     = 1'b0;
      addr_d   = '0;
      bwdata_d = '0;
      busy_d   = (state_d != S_IDLE);
      done_d   = fin_ok | fin_err;
      err_d    = fin_err;

      case (state_d)
         S_RD_STAT: begin
            req_d  = 1'b1;
            addr_d = stat_addr_d;
         end
         S_WR_DATA: begin
            req_d    = 1'b1;
            we_d     = 1'b1;
            addr_d   = data_addr_d;
            bwdata_d = wdata_d;
         end
         default: begin
            req_d = 1'b0;
         end
      endcase
   end

   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = bwdata_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;
   assign polls_o         = polls_q;

endmodule
